// File: rtl/pmux_ift_pipe.sv
// Registered one-hot pmux with taint tracking and a saturating tainted-beat counter; latency 1.
// Backpressure: in_ready = !out_valid || out_ready, so a held beat stalls input and drain+accept has no bubble.
module pmux_ift_pipe #(
  parameter int WIDTH   = 2,
  parameter int N       = 4,
  parameter int TAINT_W = 32,
  parameter int PRECISE = 0,
  parameter int CNT_W   = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [WIDTH-1:0]     A,
  input  logic [TAINT_W-1:0]   A_t,
  input  logic [WIDTH*N-1:0]   B,
  input  logic [TAINT_W*N-1:0] B_t,
  input  logic [N-1:0]         S,
  input  logic [TAINT_W-1:0]   S_t,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     Y,
  output logic [TAINT_W-1:0]   Y_t,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     taint_cnt
);

  logic [WIDTH-1:0]   sel;
  logic [TAINT_W-1:0] dt;
  logic [TAINT_W-1:0] st;
  logic [TAINT_W-1:0] nxt_t;
  logic               found;
  logic               differs;
  logic               accept;

  // Lowest set select bit wins; S == 0 falls back to A.
  always_comb begin
    sel   = A;
    dt    = A_t;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (S[i] && !found) begin
        found = 1'b1;
        sel   = B[i*WIDTH +: WIDTH];
        dt    = B_t[i*TAINT_W +: TAINT_W];
      end
    end
  end

  // The select only leaks information if some candidate would have produced a different value.
  always_comb begin
    differs = (A != sel);
    for (int i = 0; i < N; i++) begin
      if (B[i*WIDTH +: WIDTH] != sel) differs = 1'b1;
    end
  end

  assign st       = ((PRECISE == 0) || differs) ? S_t : '0;
  assign nxt_t    = dt | st;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      Y         <= '0;
      Y_t       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      Y         <= sel;
      Y_t       <= nxt_t;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      taint_cnt <= '0;
    end else if (cnt_clr) begin
      taint_cnt <= '0;
    end else if (accept && (nxt_t != '0) && (taint_cnt != {CNT_W{1'b1}})) begin
      taint_cnt <= taint_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pmux_ift_pipe.sv
// Scoreboard bench: one conservative/8-bit-counter and one precise/2-bit-counter instance share stimulus.
module tb_pmux_ift_pipe;
  localparam int W  = 2;
  localparam int N  = 4;
  localparam int TW = 32;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic            RST_N;
  logic [W-1:0]    A;
  logic [TW-1:0]   A_t;
  logic [W*N-1:0]  B;
  logic [TW*N-1:0] B_t;
  logic [N-1:0]    S;
  logic [TW-1:0]   S_t;
  logic            in_valid, out_ready, cnt_clr;

  logic            ir_c, ov_c, ir_p, ov_p;
  logic [W-1:0]    y_c, y_p;
  logic [TW-1:0]   yt_c, yt_p;
  logic [7:0]      cnt_c;
  logic [1:0]      cnt_p;

  pmux_ift_pipe #(.WIDTH(W), .N(N), .TAINT_W(TW), .PRECISE(0), .CNT_W(8)) dut_c (
    .CLK(CLK), .RST_N(RST_N), .A(A), .A_t(A_t), .B(B), .B_t(B_t), .S(S), .S_t(S_t),
    .in_valid(in_valid), .in_ready(ir_c), .Y(y_c), .Y_t(yt_c), .out_valid(ov_c),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .taint_cnt(cnt_c));

  pmux_ift_pipe #(.WIDTH(W), .N(N), .TAINT_W(TW), .PRECISE(1), .CNT_W(2)) dut_p (
    .CLK(CLK), .RST_N(RST_N), .A(A), .A_t(A_t), .B(B), .B_t(B_t), .S(S), .S_t(S_t),
    .in_valid(in_valid), .in_ready(ir_p), .Y(y_p), .Y_t(yt_p), .out_valid(ov_p),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .taint_cnt(cnt_p));

  typedef struct {
    logic [W-1:0]  y;
    logic [TW-1:0] yt_c;
    logic [TW-1:0] yt_p;
  } beat_t;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Model state for the cycle currently visible on the outputs, and for the next one.
  bit cur_v = 0, nxt_v = 0, cur_zero = 1, nxt_zero = 1, chk_en = 0;
  int cur_cc = 0, nxt_cc = 0, cur_cp = 0, nxt_cp = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic beat_t ref_beat();
    beat_t        b;
    int           win = -1;
    logic [W-1:0] cand[N+1];
    bit           diff = 0;
    cand[0] = A;
    for (int i = 0; i < N; i++) cand[i+1] = B[i*W +: W];
    for (int i = N - 1; i >= 0; i--) if (S[i]) win = i;
    b.y = cand[win + 1];
    for (int i = 0; i <= N; i++) if (cand[i] != b.y) diff = 1;
    b.yt_c = (win < 0 ? A_t : B_t[win*TW +: TW]) | S_t;
    b.yt_p = (win < 0 ? A_t : B_t[win*TW +: TW]) | (diff ? S_t : '0);
    return b;
  endfunction

  task automatic plan();
    beat_t b;
    bit    acc;
    if (!RST_N) begin
      sb.delete();
      nxt_v = 0; nxt_cc = 0; nxt_cp = 0; nxt_zero = 1;
    end else begin
      acc = in_valid && (!cur_v || out_ready);
      b   = ref_beat();
      if (acc) sb.push_back(b);
      nxt_v    = acc || (cur_v && !out_ready);
      nxt_zero = acc ? 0 : cur_zero;
      nxt_cc   = cnt_clr ? 0 : (acc && b.yt_c != 0 && cur_cc < 255) ? cur_cc + 1 : cur_cc;
      nxt_cp   = cnt_clr ? 0 : (acc && b.yt_p != 0 && cur_cp < 3)   ? cur_cp + 1 : cur_cp;
    end
  endtask

  task automatic cyc();
    plan();
    @(posedge CLK);
    #1;
    cur_v = nxt_v; cur_zero = nxt_zero; cur_cc = nxt_cc; cur_cp = nxt_cp;
    chk_en = 1;
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("out_valid_c", ov_c, cur_v);
      check("out_valid_p", ov_p, cur_v);
      check("in_ready_c", ir_c, !cur_v || out_ready);
      check("in_ready_p", ir_p, !cur_v || out_ready);
      check("taint_cnt_c", cnt_c, cur_cc);
      check("taint_cnt_p", cnt_p, cur_cp);
      if (cur_zero) begin
        check("y_after_reset", {y_c, y_p}, 0);
        check("yt_after_reset", {yt_c, yt_p}, 0);
      end
      if (RST_N && cur_v) begin
        if (sb.size() == 0) begin
          check("scoreboard_has_beat", 0, 1);
        end else begin
          check("y_c", y_c, sb[0].y);
          check("y_p", y_p, sb[0].y);
          check("yt_c", yt_c, sb[0].yt_c);
          check("yt_p", yt_p, sb[0].yt_p);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic idle_inputs();
    A = '0; A_t = '0; B = '0; B_t = '0; S = '0; S_t = '0;
    in_valid = 0; out_ready = 1; cnt_clr = 0;
  endtask

  initial begin
    idle_inputs();
    // Reset held two cycles with a beat offered
    RST_N = 0; in_valid = 1; A = 2'b10; A_t = 32'h4;
    cyc(); cyc();
    RST_N = 1;

    // Plain A path
    idle_inputs();
    A = 2'b01; A_t = 32'h1; in_valid = 1;
    cyc();

    // All candidates equal: precise drops select taint
    A = 2'b11; A_t = '0; B = 8'hFF; B_t = '0; S = 4'b0100; S_t = 32'h8;
    cyc();

    // Multi-hot select: lowest index wins
    B = 8'b11_01_10_00; B_t = '0; B_t[1*TW +: TW] = 32'h10; S = 4'b0110; S_t = 32'h2;
    cyc();

    // Backpressure for 3 cycles, then drain+accept
    out_ready = 0; A = 2'b00; S = 4'b0001; B[0 +: W] = 2'b01; B_t[0 +: TW] = 32'h20;
    repeat (3) cyc();
    out_ready = 1;
    cyc();
    in_valid = 0;
    cyc();

    // Counter saturation, then clear racing a tainted accept
    S = '0; A_t = 32'h1; S_t = '0; in_valid = 1;
    repeat (5) cyc();
    cnt_clr = 1;
    cyc();
    cnt_clr = 0;
    out_ready = 0;
    cyc();
    // Reset while a beat is held
    RST_N = 0;
    cyc();
    RST_N = 1; in_valid = 0; out_ready = 1;
    cyc();

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      RST_N     = ($urandom_range(0, 199) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      A         = W'($urandom_range(0, 3));
      A_t       = ($urandom_range(0, 1) != 0) ? (32'h1 << $urandom_range(0, 31)) : '0;
      S_t       = ($urandom_range(0, 1) != 0) ? (32'h1 << $urandom_range(0, 31)) : '0;
      for (int i = 0; i < N; i++) begin
        B[i*W +: W]    = ($urandom_range(0, 3) == 0) ? A : W'($urandom_range(0, 3));
        B_t[i*TW +: TW] = ($urandom_range(0, 1) != 0) ? (32'h1 << $urandom_range(0, 31)) : '0;
      end
      case ($urandom_range(0, 3))
        0:       S = '0;
        1, 2:    S = N'(1 << $urandom_range(0, N - 1));
        default: S = N'($urandom_range(0, 15));
      endcase
      cyc();
    end

    RST_N = 1; in_valid = 0; out_ready = 1; cnt_clr = 0;
    repeat (3) cyc();
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
